// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the Mini-SRC hardwired control unit: opcodes, ALU codes,
// sequencer states, the control strobe vector and small decode helpers.
package cpu_ctrl_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01001, OP_OR   = 5'b01010, OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111;
   localparam logic [4:0] OP_MFLO = 5'b11000, OP_NOP  = 5'b11001, OP_HALT = 5'b11010;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SHR = 4'd4, ALU_SHL = 4'd5, ALU_ROR = 4'd6, ALU_ROL = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8, ALU_DIV = 4'd9, ALU_NEG = 4'd10, ALU_NOT = 4'd11;
   localparam logic [3:0] ALU_INC = 4'd12;

   typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT, PAUSE} state_t;

   typedef enum logic [4:0] {
      CL_ALU, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_MD, CL_UN, CL_BR, CL_JR,
      CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILL
   } op_class_t;

   typedef struct packed {
      logic PCin, PCout, IncPC, IRin, Yin, MARin, MDRin, MDRout, Read, wren;
      logic HIin, HIout, LOin, LOout, Zhighin, Zlowin, Zhighout, Zlowout, Cout;
      logic InPortout, outPortEnable, Gra, Grb, Grc, Rin, Rout, BAout, conInput, IRout;
   } strobes_t;

   typedef struct packed {
      strobes_t   s;
      logic [3:0] ctrl;
      logic       last;
      logic       halt;
      logic       illegal;
   } dec_t;

   function automatic op_class_t op_class(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: return CL_ALU;
         OP_ADDI, OP_ANDI, OP_ORI: return CL_IMM;
         OP_LD:   return CL_LD;
         OP_LDI:  return CL_LDI;
         OP_ST:   return CL_ST;
         OP_MUL, OP_DIV: return CL_MD;
         OP_NEG, OP_NOT: return CL_UN;
         OP_BR:   return CL_BR;
         OP_JR:   return CL_JR;
         OP_JAL:  return CL_JAL;
         OP_IN:   return CL_IN;
         OP_OUT:  return CL_OUT;
         OP_MFHI: return CL_MFHI;
         OP_MFLO: return CL_MFLO;
         OP_NOP:  return CL_NOP;
         OP_HALT: return CL_HALT;
         default: return CL_ILL;
      endcase
   endfunction

   function automatic logic [3:0] alu_of(input logic [4:0] op);
      case (op)
         OP_SUB:          return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR, OP_ORI:   return ALU_OR;
         OP_SHR:          return ALU_SHR;
         OP_SHL:          return ALU_SHL;
         OP_ROR:          return ALU_ROR;
         OP_ROL:          return ALU_ROL;
         OP_MUL:          return ALU_MUL;
         OP_DIV:          return ALU_DIV;
         OP_NEG:          return ALU_NEG;
         OP_NOT:          return ALU_NOT;
         default:         return ALU_ADD;
      endcase
   endfunction

   function automatic state_t next_step(input state_t s);
      case (s)
         T0:      return T1;
         T1:      return T2;
         T2:      return T3;
         T3:      return T4;
         T4:      return T5;
         T5:      return T6;
         T6:      return T7;
         default: return T0;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction/condition inputs and datapath control outputs of the sequencer.
// The optional single-step input (SINGLE_STEP_EN) is a plain port on the top, not part of this bundle.
interface control_sequencer_if;
   logic [31:0] ir;
   logic        con_ff, Stop, Run, illegal_op;
   logic [3:0]  ctrl;
   logic PCin, PCout, IncPC, IRin, Yin, MARin, MDRin, MDRout, Read, wren;
   logic HIin, HIout, LOin, LOout, Zhighin, Zlowin, Zhighout, Zlowout, Cout;
   logic InPortout, outPortEnable, Gra, Grb, Grc, Rin, Rout, BAout, conInput, IRout;

   modport master (
      input  ir, con_ff, Stop,
      output Run, illegal_op, ctrl,
      output PCin, PCout, IncPC, IRin, Yin, MARin, MDRin, MDRout, Read, wren,
      output HIin, HIout, LOin, LOout, Zhighin, Zlowin, Zhighout, Zlowout, Cout,
      output InPortout, outPortEnable, Gra, Grb, Grc, Rin, Rout, BAout, conInput, IRout
   );

   modport slave (
      output ir, con_ff, Stop,
      input  Run, illegal_op, ctrl,
      input  PCin, PCout, IncPC, IRin, Yin, MARin, MDRin, MDRout, Read, wren,
      input  HIin, HIout, LOin, LOout, Zhighin, Zlowin, Zhighout, Zlowout, Cout,
      input  InPortout, outPortEnable, Gra, Grb, Grc, Rin, Rout, BAout, conInput, IRout
   );
endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational Moore decode of (state, opcode, con_ff) into the datapath strobe vector,
// plus flags telling the sequencer where an instruction ends.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [4:0] opcode,
   input  logic       con_ff,
   output dec_t       dec
);

   op_class_t  cls_s;
   logic [3:0] alu_s;

   assign cls_s = op_class(opcode);
   assign alu_s = alu_of(opcode);

   // Strobe decode: everything low by default, each step raises only its own strobes
   always_comb begin
      dec = '0;
      case (state)
         T0: begin dec.s.PCout = 1'b1; dec.s.MARin = 1'b1; dec.s.IncPC = 1'b1; dec.s.Zlowin = 1'b1; dec.ctrl = ALU_INC; end
         T1: begin dec.s.Zlowout = 1'b1; dec.s.PCin = 1'b1; dec.s.Read = 1'b1; dec.s.MDRin = 1'b1; end
         T2: begin dec.s.MDRout = 1'b1; dec.s.IRin = 1'b1; end
         T3, T4, T5, T6, T7: begin
            case (cls_s)
               CL_ALU, CL_IMM: begin
                  case (state)
                     T3: begin dec.s.Grb = 1'b1; dec.s.Rout = 1'b1; dec.s.Yin = 1'b1; end
                     T4: begin
                        if (cls_s == CL_IMM) dec.s.Cout = 1'b1;
                        else begin dec.s.Grc = 1'b1; dec.s.Rout = 1'b1; end
                        dec.ctrl = alu_s; dec.s.Zlowin = 1'b1;
                     end
                     T5: begin dec.s.Zlowout = 1'b1; dec.s.Gra = 1'b1; dec.s.Rin = 1'b1; dec.last = 1'b1; end
                     default: ;
                  endcase
               end
               CL_LD, CL_LDI, CL_ST: begin
                  case (state)
                     T3: begin dec.s.Grb = 1'b1; dec.s.BAout = 1'b1; dec.s.Yin = 1'b1; end
                     T4: begin dec.s.Cout = 1'b1; dec.ctrl = ALU_ADD; dec.s.Zlowin = 1'b1; end
                     T5: begin
                        dec.s.Zlowout = 1'b1;
                        if (cls_s == CL_LDI) begin dec.s.Gra = 1'b1; dec.s.Rin = 1'b1; dec.last = 1'b1; end
                        else dec.s.MARin = 1'b1;
                     end
                     // st latches the source register into MDR without a memory read
                     T6: begin
                        dec.s.MDRin = 1'b1;
                        if (cls_s == CL_LD) dec.s.Read = 1'b1;
                        else begin dec.s.Gra = 1'b1; dec.s.Rout = 1'b1; end
                     end
                     T7: begin
                        dec.last = 1'b1;
                        if (cls_s == CL_LD) begin dec.s.MDRout = 1'b1; dec.s.Gra = 1'b1; dec.s.Rin = 1'b1; end
                        else dec.s.wren = 1'b1;
                     end
                     default: ;
                  endcase
               end
               CL_MD: begin
                  case (state)
                     T3: begin dec.s.Gra = 1'b1; dec.s.Rout = 1'b1; dec.s.Yin = 1'b1; end
                     T4: begin dec.s.Grb = 1'b1; dec.s.Rout = 1'b1; dec.ctrl = alu_s; dec.s.Zhighin = 1'b1; dec.s.Zlowin = 1'b1; end
                     T5: begin dec.s.Zlowout = 1'b1; dec.s.LOin = 1'b1; end
                     T6: begin dec.s.Zhighout = 1'b1; dec.s.HIin = 1'b1; dec.last = 1'b1; end
                     default: ;
                  endcase
               end
               CL_UN: begin
                  case (state)
                     T3: begin dec.s.Grb = 1'b1; dec.s.Rout = 1'b1; dec.ctrl = alu_s; dec.s.Zlowin = 1'b1; end
                     T4: begin dec.s.Zlowout = 1'b1; dec.s.Gra = 1'b1; dec.s.Rin = 1'b1; dec.last = 1'b1; end
                     default: ;
                  endcase
               end
               CL_BR: begin
                  case (state)
                     T3: begin dec.s.Gra = 1'b1; dec.s.Rout = 1'b1; dec.s.conInput = 1'b1; end
                     T4: begin dec.s.PCout = 1'b1; dec.s.Yin = 1'b1; end
                     T5: begin dec.s.Cout = 1'b1; dec.ctrl = ALU_ADD; dec.s.Zlowin = 1'b1; end
                     T6: begin
                        dec.last = 1'b1;
                        if (con_ff) begin dec.s.Zlowout = 1'b1; dec.s.PCin = 1'b1; end
                        else dec.s.PCin = 1'b0;
                     end
                     default: ;
                  endcase
               end
               CL_JAL: begin
                  case (state)
                     T3: begin dec.s.PCout = 1'b1; dec.s.Grb = 1'b1; dec.s.Rin = 1'b1; end
                     T4: begin dec.s.Gra = 1'b1; dec.s.Rout = 1'b1; dec.s.PCin = 1'b1; dec.last = 1'b1; end
                     default: ;
                  endcase
               end
               // Remaining classes are single-step instructions that finish at T3
               CL_JR:   begin dec.s.Gra = 1'b1; dec.s.Rout = 1'b1; dec.s.PCin = 1'b1; dec.last = 1'b1; end
               CL_IN:   begin dec.s.InPortout = 1'b1; dec.s.Gra = 1'b1; dec.s.Rin = 1'b1; dec.last = 1'b1; end
               CL_OUT:  begin dec.s.Gra = 1'b1; dec.s.Rout = 1'b1; dec.s.outPortEnable = 1'b1; dec.last = 1'b1; end
               CL_MFHI: begin dec.s.HIout = 1'b1; dec.s.Gra = 1'b1; dec.s.Rin = 1'b1; dec.last = 1'b1; end
               CL_MFLO: begin dec.s.LOout = 1'b1; dec.s.Gra = 1'b1; dec.s.Rin = 1'b1; dec.last = 1'b1; end
               CL_NOP:  dec.last = 1'b1;
               CL_HALT: begin dec.halt = 1'b1; dec.last = 1'b1; end
               default: begin dec.illegal = 1'b1; dec.last = 1'b1; end
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Mini-SRC hardwired control unit: state register, memory-wait counter and Stop handling.
// Define SINGLE_STEP_EN to add the `step` input and the PAUSE state between instructions.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 1
)
(
   input logic Clock,
   input logic Clear,
`ifdef SINGLE_STEP_EN
   input logic step,
`endif
   control_sequencer_if.master bus
);

   localparam logic [1:0] MW = 2'(MEM_WAIT);
`ifdef SINGLE_STEP_EN
   localparam state_t RET_STATE = PAUSE;
`else
   localparam state_t RET_STATE = T0;
`endif

   state_t     state_r, next_s;
   logic [1:0] wait_r;
   logic       hold_s;
   dec_t       dec_s;
   logic       unused_ir_s;

   // Only the opcode field steers sequencing; operand fields belong to the datapath
   assign unused_ir_s = ^bus.ir[26:0];

   ctrl_decode u_decode (
      .state  (state_r),
      .opcode (bus.ir[31:27]),
      .con_ff (bus.con_ff),
      .dec    (dec_s)
   );

   assign {bus.PCin, bus.PCout, bus.IncPC, bus.IRin, bus.Yin, bus.MARin, bus.MDRin, bus.MDRout,
           bus.Read, bus.wren, bus.HIin, bus.HIout, bus.LOin, bus.LOout, bus.Zhighin, bus.Zlowin,
           bus.Zhighout, bus.Zlowout, bus.Cout, bus.InPortout, bus.outPortEnable, bus.Gra, bus.Grb,
           bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.conInput, bus.IRout} = dec_s.s;
   assign bus.ctrl       = dec_s.ctrl;
   assign bus.illegal_op = dec_s.illegal;
   assign bus.Run        = (state_r != RESET) && (state_r != HALT);

   // Next-state: read steps stretch by MEM_WAIT cycles; Stop only counts on an instruction's last step
   always_comb begin
      next_s = state_r;
      hold_s = 1'b0;
      case (state_r)
         RESET: next_s = T0;
         HALT:  next_s = HALT;
         PAUSE: begin
`ifdef SINGLE_STEP_EN
            if (bus.Stop)  next_s = HALT;
            else if (step) next_s = T0;
            else           next_s = PAUSE;
`else
            next_s = T0;
`endif
         end
         default: begin
            if (dec_s.s.Read && (wait_r != MW)) begin
               hold_s = 1'b1;
               next_s = state_r;
            end else if (dec_s.last) begin
               if (dec_s.halt || bus.Stop) next_s = HALT;
               else                        next_s = RET_STATE;
            end else begin
               next_s = next_step(state_r);
            end
         end
      endcase
   end

   // State register and saturating read-hold counter
   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_r <= RESET;
         wait_r  <= 2'd0;
      end else begin
         state_r <= next_s;
         wait_r  <= hold_s ? (wait_r + 2'd1) : 2'd0;
      end
   end

endmodule
